// File: rtl/hit_write_arbiter.sv
// Round-robin arbiter that turns port/IP/MAC/URL match pulses into tagged
// 32-bit hit records and writes them to a circular buffer over Avalon-MM.
module hit_write_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 256
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        sop,
    input  logic        port_match,
    input  logic        ip_match,
    input  logic        mac_match,
    input  logic        url_match,
    input  logic        flush,
    input  logic        wait_request,
    output logic        write_enable,
    output logic [31:0] addr_out,
    output logic [31:0] data_out,
    output logic [3:0]  pending,
    output logic [7:0]  drop_count,
    output logic        wrapped
);

    localparam int IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t             state_r, state_s;
    logic [23:0]        pkt_cnt_r, pkt_cnt_s;
    logic [3:0][23:0]   tag_r, tag_s;
    logic [3:0]         pending_r, pending_s;
    logic [7:0]         drop_count_r, drop_count_s;
    logic               wrapped_r, wrapped_s;
    logic [1:0]         rr_last_r, rr_last_s;
    logic [IDX_W-1:0]   wr_idx_r, wr_idx_s;
    logic               flush_hold_r, flush_hold_s;
    logic [1:0]         winner_r, winner_s;
    logic               write_enable_r, write_enable_s;
    logic [31:0]        addr_r, addr_s;
    logic [31:0]        data_r, data_s;

    logic [3:0]         match_s;
    logic [3:0]         clear_s;
    logic [23:0]        tag_val_s;
    logic               accept_s;
    logic               do_flush_s;
    logic [2:0]         drops_s;
    logic [8:0]         drop_sum_s;
    logic [1:0]         pick_s;

    // First pending source at or after last+1 (mod 4); caller guarantees req != 0.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] cand;
        logic [1:0] pick;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    assign match_s   = {url_match, mac_match, ip_match, port_match};
    assign tag_val_s = sop ? (pkt_cnt_r + 24'd1) : pkt_cnt_r;
    assign accept_s  = (state_r == WRITE) && !wait_request;
    assign clear_s   = accept_s ? (4'b0001 << winner_r) : 4'b0000;
    assign pick_s    = rr_pick(pending_r, rr_last_r);

    // Next-state and output logic for the arbiter FSM and all bookkeeping.
    always_comb begin
        state_s        = state_r;
        pkt_cnt_s      = tag_val_s;
        tag_s          = tag_r;
        pending_s      = pending_r;
        wrapped_s      = wrapped_r;
        rr_last_s      = rr_last_r;
        wr_idx_s       = wr_idx_r;
        flush_hold_s   = flush_hold_r;
        winner_s       = winner_r;
        write_enable_s = write_enable_r;
        addr_s         = addr_r;
        data_s         = data_r;
        do_flush_s     = 1'b0;
        drops_s        = 3'd0;

        // A pulse on a source that stays pending loses the older hit.
        for (int i = 0; i < 4; i++) begin
            if (match_s[i]) begin
                pending_s[i] = 1'b1;
                tag_s[i]     = tag_val_s;
                if (pending_r[i] && !clear_s[i]) begin
                    drops_s = drops_s + 3'd1;
                end else begin
                    drops_s = drops_s;
                end
            end else if (clear_s[i]) begin
                pending_s[i] = 1'b0;
            end else begin
                pending_s[i] = pending_r[i];
            end
        end

        drop_sum_s   = {1'b0, drop_count_r} + {6'd0, drops_s};
        drop_count_s = drop_sum_s[8] ? 8'hFF : drop_sum_s[7:0];

        case (state_r)
            IDLE: begin
                write_enable_s = 1'b0;
                if (flush) begin
                    do_flush_s = 1'b1;
                end else if (pending_r != 4'b0000) begin
                    winner_s       = pick_s;
                    write_enable_s = 1'b1;
                    addr_s         = BASE_ADDR + (32'(wr_idx_r) << 2);
                    data_s         = {pick_s, 6'b00_0000, tag_r[pick_s]};
                    state_s        = WRITE;
                end else begin
                    state_s = IDLE;
                end
            end
            WRITE: begin
                if (accept_s) begin
                    rr_last_s      = winner_r;
                    wr_idx_s       = wr_idx_r + IDX_W'(1);
                    wrapped_s      = wrapped_r | (wr_idx_r == IDX_W'(DEPTH - 1));
                    write_enable_s = 1'b0;
                    state_s        = IDLE;
                    flush_hold_s   = 1'b0;
                    do_flush_s     = flush | flush_hold_r;
                end else if (flush) begin
                    flush_hold_s = 1'b1;
                end else begin
                    flush_hold_s = flush_hold_r;
                end
            end
            default: begin
                state_s        = IDLE;
                write_enable_s = 1'b0;
            end
        endcase

        // Flush is applied last so it wins over matches, sop and accept updates.
        if (do_flush_s) begin
            pending_s    = 4'b0000;
            tag_s        = '0;
            wr_idx_s     = '0;
            pkt_cnt_s    = 24'd0;
            drop_count_s = 8'd0;
            wrapped_s    = 1'b0;
            rr_last_s    = 2'd3;
        end else begin
            pending_s = pending_s;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r        <= IDLE;
            pkt_cnt_r      <= 24'd0;
            tag_r          <= '0;
            pending_r      <= 4'b0000;
            drop_count_r   <= 8'd0;
            wrapped_r      <= 1'b0;
            rr_last_r      <= 2'd3;
            wr_idx_r       <= '0;
            flush_hold_r   <= 1'b0;
            winner_r       <= 2'd0;
            write_enable_r <= 1'b0;
            addr_r         <= BASE_ADDR;
            data_r         <= 32'd0;
        end else begin
            state_r        <= state_s;
            pkt_cnt_r      <= pkt_cnt_s;
            tag_r          <= tag_s;
            pending_r      <= pending_s;
            drop_count_r   <= drop_count_s;
            wrapped_r      <= wrapped_s;
            rr_last_r      <= rr_last_s;
            wr_idx_r       <= wr_idx_s;
            flush_hold_r   <= flush_hold_s;
            winner_r       <= winner_s;
            write_enable_r <= write_enable_s;
            addr_r         <= addr_s;
            data_r         <= data_s;
        end
    end

    assign write_enable = write_enable_r;
    assign addr_out     = addr_r;
    assign data_out     = data_r;
    assign pending      = pending_r;
    assign drop_count   = drop_count_r;
    assign wrapped      = wrapped_r;

endmodule
